// File: rtl/rv32i_pkg.sv
// Shared decode constants and ALU operation type for the RV32I integer datapath.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [6:0] F7_ADD     = 7'b0000000;
  localparam logic [6:0] F7_SUB     = 7'b0100000;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_op_t;

endpackage

// File: rtl/rv32i_mpu_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write port,
// x0 hard-wired to zero, x1/x2 loaded with parameterised values on reset.
module rv32i_mpu_regfile #(
  parameter logic [31:0] R1_INIT = 32'd0,
  parameter logic [31:0] R2_INIT = 32'd0
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata
);

  logic [31:0] r_regs [32];

  // Reset must initialise every entry, so this is a flop array rather than RAM.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= (i == 1) ? R1_INIT : (i == 2) ? R2_INIT : 32'd0;
      end
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : r_regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : r_regs[i_raddr2];

endmodule

// File: rtl/rv32i_mpu.sv
// Single-cycle RV32I ADD/SUB execute slice: decode, register read, ALU and writeback.
// Every instruction other than OP/ADD and OP/SUB executes as a NOP.
module rv32i_mpu
  import rv32i_pkg::*;
#(
  parameter logic [31:0] R1_INIT = 32'd0,
  parameter logic [31:0] R2_INIT = 32'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data
);

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [6:0]  w_funct7;
  logic        w_valid;
  logic        w_we;
  alu_op_t     w_alu_op;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;
  logic [31:0] w_alu_res;

  logic        r_wb_valid;
  logic [4:0]  r_wb_addr;
  logic [31:0] r_wb_data;

  assign w_opcode = instr[6:0];
  assign w_rd     = instr[11:7];
  assign w_funct3 = instr[14:12];
  assign w_rs1    = instr[19:15];
  assign w_rs2    = instr[24:20];
  assign w_funct7 = instr[31:25];

  assign w_valid  = (w_opcode == OPC_OP) && (w_funct3 == F3_ADD_SUB) &&
                    ((w_funct7 == F7_ADD) || (w_funct7 == F7_SUB));
  assign w_we     = w_valid && (w_rd != 5'd0);
  assign w_alu_op = w_funct7[5] ? ALU_SUB : ALU_ADD;

  rv32i_mpu_regfile #(
    .R1_INIT (R1_INIT),
    .R2_INIT (R2_INIT)
  ) u_regfile (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .o_rdata1 (w_rs1_val),
    .o_rdata2 (w_rs2_val),
    .i_we     (w_we),
    .i_waddr  (w_rd),
    .i_wdata  (w_alu_res)
  );

  always_comb begin
    w_alu_res = w_rs1_val + w_rs2_val;
    if (w_alu_op == ALU_SUB) begin
      w_alu_res = w_rs1_val - w_rs2_val;
    end
  end

  // wb_addr/wb_data keep the last write; only wb_valid pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wb_valid <= 1'b0;
      r_wb_addr  <= 5'd0;
      r_wb_data  <= 32'd0;
    end else begin
      r_wb_valid <= w_we;
      if (w_we) begin
        r_wb_addr <= w_rd;
        r_wb_data <= w_alu_res;
      end
    end
  end

  assign wb_valid = r_wb_valid;
  assign wb_addr  = r_wb_addr;
  assign wb_data  = r_wb_data;

endmodule

// File: tb/tb_rv32i_mpu.sv
// Self-checking bench for rv32i_mpu: directed test-plan cases plus random
// instruction streams checked against an architectural register model.
module tb_rv32i_mpu;

  localparam logic [31:0] R1_INIT = 32'd5;
  localparam logic [31:0] R2_INIT = 32'd11;

  logic        clock;
  logic        reset;
  logic [31:0] instr;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int n_checks;
  int n_fail;

  // Architectural model state.
  logic [31:0] m_regs [32];
  logic        e_valid;
  logic [4:0]  e_addr;
  logic [31:0] e_data;

  rv32i_mpu #(R1_INIT, R2_INIT) dut (
    .clock    (clock),
    .reset    (reset),
    .instr    (instr),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic sub, input int rd, input int rs1, input int rs2);
    logic [6:0] f7;
    f7 = sub ? 7'b0100000 : 7'b0000000;
    return {f7, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction

  // Reference: apply one instruction word (or reset) to the architectural state.
  task automatic model(input logic [31:0] ins, input logic rst);
    int rd, rs1, rs2;
    logic [31:0] a, b, res;
    bit ok;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_regs[1] = R1_INIT;
      m_regs[2] = R2_INIT;
      e_valid = 1'b0;
      e_addr  = 5'd0;
      e_data  = 32'd0;
      return;
    end
    rd  = int'(ins[11:7]);
    rs1 = int'(ins[19:15]);
    rs2 = int'(ins[24:20]);
    ok  = (ins[6:0] == 7'h33) && (ins[14:12] == 3'd0) &&
          (ins[31:25] == 7'h00 || ins[31:25] == 7'h20);
    a   = m_regs[rs1];
    b   = m_regs[rs2];
    res = (ins[31:25] == 7'h20) ? a - b : a + b;
    if (ok && rd != 0) begin
      m_regs[rd] = res;
      e_valid = 1'b1;
      e_addr  = 5'(rd);
      e_data  = res;
    end else begin
      e_valid = 1'b0;
    end
  endtask

  task automatic step(input string tag, input logic [31:0] ins, input logic rst);
    @(negedge clock);
    reset = rst;
    instr = ins;
    @(posedge clock);
    model(ins, rst);
    #1;
    check({tag, ".wb_valid"}, 32'(wb_valid), 32'(e_valid));
    check({tag, ".wb_addr"},  32'(wb_addr),  32'(e_addr));
    check({tag, ".wb_data"},  wb_data,       e_data);
    $display("txn %-10s rst=%0d instr=%08h wb_valid=%0d wb_addr=%0d wb_data=%08h",
             tag, rst, ins, wb_valid, wb_addr, wb_data);
  endtask

  // Expose register r through the writeback port by copying it into x31.
  task automatic peek(input string tag, input int r, input logic [31:0] exp);
    step(tag, enc(1'b0, 31, r, 0), 1'b0);
    check({tag, ".value"}, wb_data, exp);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    instr    = 32'd0;

    for (int i = 0; i < 5; i++) step("reset", 32'd0, 1'b1);

    for (int i = 0; i < 3; i++) begin
      step("sub_x3", enc(1'b1, 3, 1, 2), 1'b0);
      check("sub_x3.value", wb_data, 32'hFFFF_FFFA);
    end
    peek("peek_x3", 3, 32'hFFFF_FFFA);

    step("add_x3", enc(1'b0, 3, 1, 2), 1'b0);
    check("add_x3.value", wb_data, 32'd16);
    peek("peek_x1", 1, 32'd5);
    peek("peek_x2", 2, 32'd11);

    step("add_x0", enc(1'b0, 0, 1, 2), 1'b0);
    check("add_x0.nowb", 32'(wb_valid), 32'd0);
    peek("peek_x0", 0, 32'd0);

    step("bad_opc", {7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0010011}, 1'b0);
    step("bad_f3",  {7'h00, 5'd2, 5'd1, 3'b001, 5'd3, 7'b0110011}, 1'b0);
    step("bad_f7",  {7'h01, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}, 1'b0);
    step("zero",    32'd0, 1'b0);
    peek("peek_x3b", 3, 32'd16);

    step("add_x1_1", enc(1'b0, 1, 1, 2), 1'b0);
    check("acc1", wb_data, 32'd16);
    step("add_x1_2", enc(1'b0, 1, 1, 2), 1'b0);
    check("acc2", wb_data, 32'd27);
    step("add_x1_3", enc(1'b0, 1, 1, 2), 1'b0);
    check("acc3", wb_data, 32'd38);

    // Build x9 = 1 and x1 = -1 from the init values, then wrap x1 to zero.
    step("reset2", 32'd0, 1'b1);
    step("mk6",  enc(1'b1, 8, 2, 1), 1'b0);
    step("mk1",  enc(1'b1, 9, 8, 1), 1'b0);
    step("mkm1", enc(1'b1, 10, 0, 9), 1'b0);
    step("mvx1", enc(1'b0, 1, 10, 0), 1'b0);
    check("x1_allones", wb_data, 32'hFFFF_FFFF);
    step("wrap", enc(1'b0, 1, 1, 9), 1'b0);
    check("wrap.value", wb_data, 32'd0);

    step("pend", enc(1'b0, 3, 1, 2), 1'b0);
    step("mid_rst", enc(1'b0, 3, 1, 2), 1'b1);
    check("mid_rst.valid", 32'(wb_valid), 32'd0);
    peek("rst_x1", 1, 32'd5);
    peek("rst_x2", 2, 32'd11);
    peek("rst_x3", 3, 32'd0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] w;
      int sel;
      sel = int'($urandom_range(0, 99));
      if (sel < 75) w = enc(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                            int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      else w = $urandom;
      step("rand", w, (sel == 99) ? 1'b1 : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
